// File: rtl/filter_pkg.sv
// Shared types and constants for the 5x5 filter line-buffer sequencer:
// FSM state encoding, memory-select width and vertical pad flag bit positions.
package filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        GAP,
        FLUSH,
        DONE
    } state_e;

    localparam int SEL_W    = 2;

    localparam int PAD_TOP0 = 0;
    localparam int PAD_TOP1 = 1;
    localparam int PAD_BOT0 = 2;
    localparam int PAD_BOT1 = 3;

    // line_idx is the input line being written; its output row is line_idx-2.
    function automatic logic [3:0] pad_flags(input int unsigned line_idx, input int unsigned v_act);
        logic [3:0] pad;
        pad = '0;
        if (line_idx == 2) begin
            pad[PAD_TOP0] = 1'b1;
        end else if (line_idx == 3) begin
            pad[PAD_TOP1] = 1'b1;
        end else if (line_idx == v_act) begin
            pad[PAD_BOT1] = 1'b1;
        end else if (line_idx == v_act + 1) begin
            pad[PAD_BOT0] = 1'b1;
        end
        return pad;
    endfunction

endpackage

// File: rtl/filter_hv_counter.sv
// Pixel / line position counters for the line-buffer sequencer.
// i_clr restarts the frame; an i_inc in the same cycle counts as pixel 0 of line 0.
module filter_hv_counter #(
    parameter int H_ACT          = 1920,
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int LINE_CNT_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_clr,
    input  logic                      i_inc,
    output logic [MEM_ADDR_WIDTH-1:0] o_hcnt,
    output logic [LINE_CNT_WIDTH-1:0] o_vcnt,
    output logic                      o_line_end
);

    localparam logic [MEM_ADDR_WIDTH-1:0] H_LAST = MEM_ADDR_WIDTH'(H_ACT - 1);

    logic [MEM_ADDR_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [LINE_CNT_WIDTH-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        o_line_end = i_inc & ~i_clr & (hcnt_q == H_LAST);
        if (i_clr) begin
            hcnt_d = i_inc ? MEM_ADDR_WIDTH'(1) : '0;
            vcnt_d = '0;
        end else if (i_inc) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = vcnt_q + LINE_CNT_WIDTH'(1);
            end else begin
                hcnt_d = hcnt_q + MEM_ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign o_hcnt = hcnt_q;
    assign o_vcnt = vcnt_q;

endmodule

// File: rtl/filter_line_ctrl_5x5.sv
// Line-buffer sequencer for the 5x5 filter align stage, including the two self-generated flush lines.
// Define FILTER_LINE_CTRL_ERR_EN to build the sticky protocol checker behind o_err.
module filter_line_ctrl_5x5
    import filter_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int LINE_CNT_WIDTH = 12,
    parameter int H_ACT          = 1920,
    parameter int V_ACT          = 1080,
    parameter int FLUSH_GAP      = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_vsync,
    input  logic                      i_de,
    output logic                      o_mem_ren,
    output logic [SEL_W-1:0]          o_mem_sel,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [3:0]                o_pad_y,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic                      o_err
);

    localparam int GAP_W = $clog2(FLUSH_GAP);
    localparam logic [GAP_W-1:0]          GAP_LAST   = GAP_W'(FLUSH_GAP - 1);
    localparam logic [LINE_CNT_WIDTH-1:0] FILL_LAST  = LINE_CNT_WIDTH'(1);
    localparam logic [LINE_CNT_WIDTH-1:0] RUN_LAST   = LINE_CNT_WIDTH'(V_ACT - 1);
    localparam logic [LINE_CNT_WIDTH-1:0] FLUSH_ONE  = LINE_CNT_WIDTH'(V_ACT);

    state_e                    state_q, state_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic                      le_q, le_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [3:0]                pad_q, pad_d;
    logic [MEM_ADDR_WIDTH-1:0] waddr_q, waddr_d;

    logic                      accept_de;
    logic                      flush_rd;
    logic                      advance;
    logic [MEM_ADDR_WIDTH-1:0] hcnt;
    logic [LINE_CNT_WIDTH-1:0] vcnt;
    logic                      line_end;

    filter_hv_counter #(
        .H_ACT          (H_ACT),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .LINE_CNT_WIDTH (LINE_CNT_WIDTH)
    ) u_hv_counter (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (i_vsync),
        .i_inc      (advance),
        .o_hcnt     (hcnt),
        .o_vcnt     (vcnt),
        .o_line_end (line_end)
    );

    // A pixel coinciding with i_vsync belongs to the new frame whatever state we were in.
    always_comb begin
        accept_de = i_de & (i_vsync | (state_q == FILL) | (state_q == RUN));
        flush_rd  = ~i_vsync & (state_q == FLUSH);
        advance   = accept_de | flush_rd;
        o_mem_ren = ~i_vsync & ((i_de & (state_q == RUN)) | (state_q == FLUSH));
    end

    always_comb begin
        state_d = state_q;
        gap_d   = '0;
        if (i_vsync) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (line_end && vcnt == FILL_LAST) state_d = RUN;
                RUN:     if (line_end && vcnt == RUN_LAST)  state_d = GAP;
                GAP: begin
                    if (gap_q == GAP_LAST) state_d = FLUSH;
                    else                   gap_d   = gap_q + GAP_W'(1);
                end
                FLUSH:   if (line_end) state_d = (vcnt == FLUSH_ONE) ? GAP : DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // sel/pad follow the line counter one cycle after the line-end strobe,
    // so they move only once the last pixel's delayed write has gone out.
    always_comb begin
        le_d    = line_end;
        sel_d   = sel_q;
        pad_d   = pad_q;
        waddr_d = waddr_q;
        if (i_vsync) begin
            le_d  = 1'b0;
            sel_d = '0;
            pad_d = '0;
        end else if (le_q) begin
            sel_d = vcnt[SEL_W-1:0];
            pad_d = pad_flags(32'(vcnt), V_ACT);
        end
        if (accept_de) begin
            waddr_d = i_vsync ? '0 : hcnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gap_q   <= '0;
            le_q    <= 1'b0;
            sel_q   <= '0;
            pad_q   <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            le_q    <= le_d;
            sel_q   <= sel_d;
            pad_q   <= pad_d;
            waddr_q <= waddr_d;
        end
    end

    assign o_mem_sel    = sel_q;
    assign o_pad_y      = pad_q;
    assign o_mem_waddr  = waddr_q;
    assign o_mem_raddr  = hcnt;
    assign o_busy       = (state_q == FILL) | (state_q == RUN) | (state_q == GAP) | (state_q == FLUSH);
    assign o_frame_done = (state_q == DONE);

`ifdef FILTER_LINE_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (i_de & ~i_vsync & ((state_q == GAP) | (state_q == FLUSH) | (state_q == DONE)))
              | (i_vsync & o_busy);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule
